fnd_scan_ctrl: RTL and testbench

Parametrised multiplexed 7-segment (FND) scan controller: drives NUM_DIGITS common-anode digits from a packed hex-digit bus, with per-digit decimal point, blank and blink masks, PWM brightness and anti-ghosting blanking. It sits between the watch/stopwatch datapath (after digit splitting) and the board FND pins. It replaces fixed 4-digit scanning with a frame-synchronous, tear-free display engine.

---
 rtl/fnd_scan_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_fnd_scan_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: multiplexed common-anode 7-segment scan controller.
// Scans NUM_DIGITS digits, one SCAN_DIV-cycle slot each.
// Display inputs are frozen into a snapshot at the start of every frame,
// so a frame never shows a mix of old and new values.
// Features: PWM brightness window, a dead first cycle in every slot,
// per-digit decimal point, blank and blink masks.
// Optional: define FND_LZB_EN to enable leading-zero blanking.
module fnd_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 100_000,
    parameter int BRIGHT_W     = 2,
    parameter int BLINK_FRAMES = 250
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [7:0]              fnd_data,
    output logic [NUM_DIGITS-1:0]   fnd_com,
    output logic                    frame_start
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(NUM_DIGITS);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [31:0] STEP = 32'(SCAN_DIV >> BRIGHT_W);

    logic [SW-1:0]           slot_cnt_q, slot_cnt_d;
    logic [DW-1:0]           dig_idx_q, dig_idx_d;
    logic [FW-1:0]           frame_cnt_q, frame_cnt_d;
    logic                    blink_phase_q, blink_phase_d;

    logic [4*NUM_DIGITS-1:0] snap_digits_q, snap_digits_d;
    logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic [NUM_DIGITS-1:0]   snap_blank_q, snap_blank_d;
    logic [NUM_DIGITS-1:0]   snap_blink_q, snap_blink_d;
    logic [BRIGHT_W-1:0]     snap_bright_q, snap_bright_d;
    logic                    snap_phase_q, snap_phase_d;

    logic [7:0]              fnd_data_q, fnd_data_d;
    logic [NUM_DIGITS-1:0]   fnd_com_q, fnd_com_d;
    logic                    frame_start_q, frame_start_d;

    // Snapshot as seen by this cycle's decode: on the capture cycle the
    // live inputs are used so digit 0 of the new frame is already correct.
    logic                    cap;
    logic [4*NUM_DIGITS-1:0] eff_digits;
    logic [NUM_DIGITS-1:0]   eff_dp, eff_blank, eff_blink, lzb;
    logic [BRIGHT_W-1:0]     eff_bright;
    logic                    eff_phase;
    logic [31:0]             on_hi, slot_ext;
    logic                    in_win, dark;
    logic [3:0]              cur_val;

    function automatic logic [7:0] seg_decode(input logic [3:0] v);
        case (v)
            4'h0: seg_decode = 8'hC0;
            4'h1: seg_decode = 8'hF9;
            4'h2: seg_decode = 8'hA4;
            4'h3: seg_decode = 8'hB0;
            4'h4: seg_decode = 8'h99;
            4'h5: seg_decode = 8'h92;
            4'h6: seg_decode = 8'h82;
            4'h7: seg_decode = 8'hF8;
            4'h8: seg_decode = 8'h80;
            4'h9: seg_decode = 8'h90;
            4'hA: seg_decode = 8'h88;
            4'hB: seg_decode = 8'h83;
            4'hC: seg_decode = 8'hC6;
            4'hD: seg_decode = 8'hA1;
            4'hE: seg_decode = 8'h86;
            default: seg_decode = 8'h8E;
        endcase
    endfunction

    // Slot/digit scan counters plus per-frame snapshot and blink bookkeeping.
    always_comb begin
        cap           = (slot_cnt_q == '0) && (dig_idx_q == '0);
        slot_cnt_d    = slot_cnt_q + 1'b1;
        dig_idx_d     = dig_idx_q;
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        snap_digits_d = snap_digits_q;
        snap_dp_d     = snap_dp_q;
        snap_blank_d  = snap_blank_q;
        snap_blink_d  = snap_blink_q;
        snap_bright_d = snap_bright_q;
        snap_phase_d  = snap_phase_q;
        if (slot_cnt_q == SW'(SCAN_DIV - 1)) begin
            slot_cnt_d = '0;
            dig_idx_d  = (dig_idx_q == DW'(NUM_DIGITS - 1)) ? '0 : dig_idx_q + 1'b1;
        end
        if (cap) begin
            snap_digits_d = digits;
            snap_dp_d     = dp_mask;
            snap_blank_d  = blank_mask;
            snap_blink_d  = blink_mask;
            snap_bright_d = brightness;
            // The phase in force now belongs to the frame being captured.
            snap_phase_d  = blink_phase_q;
            if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    // Effective frame settings for the decode below.
    always_comb begin
        eff_digits = cap ? digits        : snap_digits_q;
        eff_dp     = cap ? dp_mask       : snap_dp_q;
        eff_blank  = cap ? blank_mask    : snap_blank_q;
        eff_blink  = cap ? blink_mask    : snap_blink_q;
        eff_bright = cap ? brightness    : snap_bright_q;
        eff_phase  = cap ? blink_phase_q : snap_phase_q;
    end

`ifdef FND_LZB_EN
    logic lz_run;
    // Leading-zero run from the top digit down; a dp anywhere in the run ends it.
    always_comb begin
        lz_run = 1'b1;
        lzb    = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lz_run = lz_run & (eff_digits[i*4 +: 4] == 4'h0) & ~eff_dp[i];
            lzb[i] = lz_run;
        end
    end
`else
    assign lzb = '0;
`endif

    // Segment/common decode; slot cycle 0 is never inside the on-window.
    always_comb begin
        slot_ext      = 32'(slot_cnt_q);
        on_hi         = (32'(eff_bright) + 32'd1) * STEP - 32'd1;
        in_win        = (slot_ext != 32'd0) && (slot_ext <= on_hi);
        cur_val       = eff_digits[{dig_idx_q, 2'b00} +: 4];
        dark          = eff_blank[dig_idx_q] | (eff_phase & eff_blink[dig_idx_q]) |
                        lzb[dig_idx_q];
        fnd_data_d    = seg_decode(cur_val);
        if (eff_dp[dig_idx_q]) fnd_data_d[7] = 1'b0;
        if (dark) fnd_data_d = 8'hFF;
        fnd_com_d     = '1;
        if (en && in_win) fnd_com_d[dig_idx_q] = 1'b0;
        frame_start_d = cap;
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_cnt_q    <= '0;
            dig_idx_q     <= '0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            snap_digits_q <= '0;
            snap_dp_q     <= '0;
            snap_blank_q  <= '0;
            snap_blink_q  <= '0;
            snap_bright_q <= '0;
            snap_phase_q  <= 1'b0;
            fnd_data_q    <= 8'hFF;
            fnd_com_q     <= '1;
            frame_start_q <= 1'b0;
        end else begin
            slot_cnt_q    <= slot_cnt_d;
            dig_idx_q     <= dig_idx_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            snap_digits_q <= snap_digits_d;
            snap_dp_q     <= snap_dp_d;
            snap_blank_q  <= snap_blank_d;
            snap_blink_q  <= snap_blink_d;
            snap_bright_q <= snap_bright_d;
            snap_phase_q  <= snap_phase_d;
            fnd_data_q    <= fnd_data_d;
            fnd_com_q     <= fnd_com_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign fnd_data    = fnd_data_q;
    assign fnd_com     = fnd_com_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Testbench for fnd_scan_ctrl: directed steps plus random input churn,
// compared every cycle against a frame/slot arithmetic reference model.
module tb_fnd_scan_ctrl;

    localparam int ND = 4;
    localparam int SD = 16;
    localparam int BW = 2;
    localparam int BF = 2;
    localparam int FL = ND * SD;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          en = 1'b1;
    logic [15:0]   digits = 16'h1234;
    logic [3:0]    dp_mask = '0, blank_mask = '0, blink_mask = '0;
    logic [1:0]    brightness = 2'd3;
    logic [7:0]    fnd_data;
    logic [3:0]    fnd_com;
    logic          frame_start;

    int errors = 0;
    int checks = 0;
    int p = 0;

    logic [15:0]   s_digits = '0;
    logic [3:0]    s_dp = '0, s_blank = '0, s_blink = '0;
    logic [1:0]    s_bright = '0;
    logic [7:0]    seg [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    fnd_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BRIGHT_W(BW), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .digits(digits), .dp_mask(dp_mask),
        .blank_mask(blank_mask), .blink_mask(blink_mask), .brightness(brightness),
        .fnd_data(fnd_data), .fnd_com(fnd_com), .frame_start(frame_start)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, got, exp, p);
        end
    endtask

    task automatic chk_reset();
        chk("rst_data", 32'(fnd_data), 32'hFF);
        chk("rst_com", 32'(fnd_com), 32'hF);
        chk("rst_fs", 32'(frame_start), 32'h0);
    endtask

    // One clock: model what the edge at position p produces, then compare.
    task automatic step();
        int slot, dig, f, val, hi;
        logic dark;
        logic [7:0] e_data;
        logic [3:0] e_com;
        @(posedge clk);
        slot = p % SD;
        dig  = (p / SD) % ND;
        f    = p / FL;
        if (slot == 0 && dig == 0) begin
            s_digits = digits; s_dp = dp_mask; s_blank = blank_mask;
            s_blink = blink_mask; s_bright = brightness;
        end
        hi = (int'(s_bright) + 1) * (SD >> BW) - 1;
        e_com = 4'hF;
        if (en && slot >= 1 && slot <= hi) e_com[dig] = 1'b0;
        val  = int'((s_digits >> (4 * dig)) & 16'hF);
        dark = s_blank[dig] || (s_blink[dig] && ((f / BF) % 2 == 1));
`ifdef FND_LZB_EN
        if (dig >= 1 && (s_digits >> (4 * dig)) == 16'h0 && (s_dp >> dig) == 4'h0) dark = 1'b1;
`endif
        e_data = seg[val];
        if (s_dp[dig]) e_data = e_data & 8'h7F;
        if (dark) e_data = 8'hFF;
        p++;
        #1;
        chk("fnd_com", 32'(fnd_com), 32'(e_com));
        chk("fnd_data", 32'(fnd_data), 32'(e_data));
        chk("frame_start", 32'(frame_start), (slot == 0 && dig == 0) ? 32'd1 : 32'd0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to(input int pos);
        while (p % FL != pos) step();
    endtask

    initial begin
        // Reset state, then basic 1234 scanning at full brightness.
        #12;
        chk_reset();
        @(posedge clk); #2;
        reset_n = 1'b1;
        p = 0;
        run(FL);
        // Brightness 0 changed mid-frame, then brightness 1.
        run(20);
        brightness = 2'd0;
        run_to(0); run(FL);
        brightness = 2'd1;
        run(FL);
        // Digit change during digit 2 slot.
        run_to(40);
        digits = 16'h5678;
        run_to(0); run(FL);
        // Blink on digit 0, decimal point on digit 2.
        blink_mask = 4'b0001;
        dp_mask    = 4'b0100;
        brightness = 2'd3;
        run(8 * FL);
        // Asynchronous reset in the middle of a digit 2 slot.
        run_to(37);
        #3 reset_n = 1'b0;
        #1 chk_reset();
        repeat (3) @(posedge clk);
        #1 chk_reset();
        blink_mask = '0; dp_mask = '0; en = 1'b0;
        #1 reset_n = 1'b1;
        p = 0;
        run(2 * FL);
        en = 1'b1;
        // Random churn of every input at random times.
        for (int i = 0; i < 10 * FL; i++) begin
            if ($urandom_range(0, 20) == 0) digits = 16'($urandom);
            if ($urandom_range(0, 30) == 0) dp_mask = 4'($urandom);
            if ($urandom_range(0, 30) == 0) blank_mask = 4'($urandom);
            if ($urandom_range(0, 30) == 0) blink_mask = 4'($urandom);
            if ($urandom_range(0, 30) == 0) brightness = 2'($urandom);
            if ($urandom_range(0, 40) == 0) en = ~en;
            step();
        end
        // Leading zeros, with and without a decimal point inside the run.
        en = 1'b1; blank_mask = '0; blink_mask = '0; dp_mask = '0;
        digits = 16'h0005; brightness = 2'd3;
        run_to(0); run(2 * FL);
        dp_mask = 4'b0010;
        run_to(0); run(2 * FL);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
